// File: rtl/snn_spike_encoder16.sv
// -----------------------------------------------------------------------------
// snn_spike_encoder16
//
// Rate-codes one 16-channel frame of unsigned feature magnitudes into STEPS
// spike vectors for the SNN core. Each channel owns an integrate-and-fire
// (sigma-delta) accumulator; the accumulators are visited one channel per
// cycle, so a single adder/comparator is shared by all channels.
//
// Timing per frame: NUM_CH SCAN cycles followed by one EMIT cycle, repeated
// STEPS times. Accumulator residues carry over between frames unless
// clear_acc is applied while idle.
//
// Optional feature: define SPIKE_ENC_LEAK_EN to apply a leak of
// acc >> LEAK_SHIFT to each accumulator before its feature is added.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   feat_data    feature frame, channel c at [c*FEAT_W +: FEAT_W]
//   feat_valid   feature frame valid
//   feat_ready   encoder idle and able to accept a frame
//   clear_acc    zero all accumulators (only while idle)
//   spikes_out   spike vector, held between strobes
//   spike_valid  one-cycle strobe per time step
//   step_idx     index of the step currently being produced
//   frame_done   pulses with the last spike_valid of a frame
// -----------------------------------------------------------------------------
module snn_spike_encoder16 #(
    parameter int unsigned NUM_CH     = 16,
    parameter int unsigned FEAT_W     = 8,
    parameter int unsigned ACC_W      = 10,
    parameter int unsigned THRESH     = 256,
    parameter int unsigned STEPS      = 16,
    parameter int unsigned LEAK_SHIFT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*FEAT_W-1:0] feat_data,
    input  logic                     feat_valid,
    output logic                     feat_ready,
    input  logic                     clear_acc,
    output logic [NUM_CH-1:0]        spikes_out,
    output logic                     spike_valid,
    output logic [3:0]               step_idx,
    output logic                     frame_done
);

    localparam int unsigned CH_W = $clog2(NUM_CH);
    localparam logic [ACC_W-1:0] ThreshA  = ACC_W'(THRESH);
    localparam logic [CH_W-1:0]  LastCh   = CH_W'(NUM_CH - 1);
    localparam logic [3:0]       LastStep = 4'(STEPS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StEmit
    } state_e;

    state_e                  state_q, state_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [3:0]              step_q, step_d;
    logic [ACC_W-1:0]        acc_q  [NUM_CH];
    logic [ACC_W-1:0]        acc_d  [NUM_CH];
    logic [FEAT_W-1:0]       feat_q [NUM_CH];
    logic [FEAT_W-1:0]       feat_d [NUM_CH];
    logic [NUM_CH-1:0]       asm_q, asm_d;
    logic [NUM_CH-1:0]       spikes_q, spikes_d;

    // Shared datapath for the channel currently being scanned.
    logic [ACC_W-1:0] acc_cur;
    logic [ACC_W-1:0] acc_lk;
    logic [ACC_W-1:0] sum;
    logic             fire;
    logic [ACC_W-1:0] acc_new;

    always_comb begin
        acc_cur = acc_q[ch_q];
`ifdef SPIKE_ENC_LEAK_EN
        acc_lk  = acc_cur - (acc_cur >> LEAK_SHIFT);
`else
        acc_lk  = acc_cur;
`endif
        sum     = acc_lk + ACC_W'(feat_q[ch_q]);
        fire    = (sum >= ThreshA);
        acc_new = fire ? (sum - ThreshA) : sum;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        step_d   = step_q;
        acc_d    = acc_q;
        feat_d   = feat_q;
        asm_d    = asm_q;
        spikes_d = spikes_q;

        unique case (state_q)
            StIdle: begin
                if (clear_acc) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        acc_d[i] = '0;
                    end
                end
                if (feat_valid) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        feat_d[c] = feat_data[c*FEAT_W +: FEAT_W];
                    end
                    step_d  = '0;
                    ch_d    = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                acc_d[ch_q] = acc_new;
                asm_d[ch_q] = fire;
                if (ch_q == LastCh) begin
                    // Publish the vector now so it is visible during EMIT;
                    // the last channel's bit is merged in directly.
                    spikes_d       = asm_q;
                    spikes_d[ch_q] = fire;
                    state_d        = StEmit;
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end
            StEmit: begin
                if (step_q == LastStep) begin
                    state_d = StIdle;
                end else begin
                    step_d  = step_q + 1'b1;
                    ch_d    = '0;
                    state_d = StScan;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            ch_q     <= '0;
            step_q   <= '0;
            acc_q    <= '{default: '0};
            feat_q   <= '{default: '0};
            asm_q    <= '0;
            spikes_q <= '0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            step_q   <= step_d;
            acc_q    <= acc_d;
            feat_q   <= feat_d;
            asm_q    <= asm_d;
            spikes_q <= spikes_d;
        end
    end

    assign feat_ready  = (state_q == StIdle);
    assign spike_valid = (state_q == StEmit);
    assign frame_done  = (state_q == StEmit) && (step_q == LastStep);
    assign step_idx    = step_q;
    assign spikes_out  = spikes_q;

endmodule

// File: tb/tb_snn_spike_encoder16.sv
// -----------------------------------------------------------------------------
// tb_snn_spike_encoder16
//
// Directed bench for snn_spike_encoder16. Inputs change and outputs are
// sampled on the falling clock edge; a "cycle" index n counts falling edges
// after the edge on which a frame is offered.
// -----------------------------------------------------------------------------
module tb_snn_spike_encoder16;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] feat_data;
    logic         feat_valid;
    logic         feat_ready;
    logic         clear_acc;
    logic [15:0]  spikes_out;
    logic         spike_valid;
    logic [3:0]   step_idx;
    logic         frame_done;

    int n_cmp = 0;
    int n_err = 0;

    // Results captured by run_frame.
    logic [15:0] got_vec [16];
    int          got_t   [16];
    logic        got_fd  [16];
    int          got_n;
    bit          got_to;

    always #5 clk = ~clk;

    snn_spike_encoder16 dut (
        .clk         (clk),
        .reset       (reset),
        .feat_data   (feat_data),
        .feat_valid  (feat_valid),
        .feat_ready  (feat_ready),
        .clear_acc   (clear_acc),
        .spikes_out  (spikes_out),
        .spike_valid (spike_valid),
        .step_idx    (step_idx),
        .frame_done  (frame_done)
    );

    // Offers one frame, then records every strobe until frame_done or timeout.
    task automatic run_frame(input logic [127:0] fd, input bit clr);
        int  n;
        int  waitc;
        bit  done;
        got_n  = 0;
        got_to = 0;
        waitc  = 0;
        done   = 0;
        @(negedge clk);
        while (!feat_ready && waitc < 400) begin
            @(negedge clk);
            waitc++;
        end
        feat_data  = fd;
        feat_valid = 1'b1;
        clear_acc  = clr;
        @(negedge clk);
        feat_valid = 1'b0;
        clear_acc  = 1'b0;
        n = 1;
        while (!done && n <= 300) begin
            if (spike_valid) begin
                if (got_n < 16) begin
                    got_vec[got_n] = spikes_out;
                    got_t[got_n]   = n;
                    got_fd[got_n]  = frame_done;
                end
                got_n++;
                if (frame_done) done = 1;
            end
            if (!done) begin
                @(negedge clk);
                n++;
            end
        end
        if (!done) got_to = 1;
    endtask

    task automatic test_reset();
        int cnt;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (feat_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready got=%b exp=1", feat_ready);
        end
        n_cmp++;
        if (spikes_out !== 16'h0000) begin
            n_err++; $display("FAIL reset_spikes got=%h exp=0000", spikes_out);
        end
        n_cmp++;
        if (spike_valid !== 1'b0 || frame_done !== 1'b0) begin
            n_err++; $display("FAIL reset_strobes got=%b%b exp=00", spike_valid, frame_done);
        end
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (spike_valid !== 1'b0) cnt++;
        end
        n_cmp++;
        if (cnt != 0) begin
            n_err++; $display("FAIL idle_no_strobe got=%0d exp=0", cnt);
        end
    endtask

    task automatic test_all128();
        logic [127:0] fd;
        logic [15:0]  ev;
        fd = {16{8'd128}};
        run_frame(fd, 1'b1);
        n_cmp++;
        if (got_to || got_n != 16) begin
            n_err++; $display("FAIL all128_count got=%0d to=%0d exp=16", got_n, got_to);
        end
        for (int i = 0; i < 16; i++) begin
            ev = (i % 2 == 1) ? 16'hFFFF : 16'h0000;
            n_cmp++;
            if (got_vec[i] !== ev || got_t[i] != 17 * (i + 1) || got_fd[i] !== (i == 15)) begin
                n_err++;
                $display("FAIL all128_step%0d got vec=%h t=%0d fd=%b exp vec=%h t=%0d fd=%b",
                         i, got_vec[i], got_t[i], got_fd[i], ev, 17 * (i + 1), (i == 15));
            end
        end
        @(negedge clk);
        n_cmp++;
        if (feat_ready !== 1'b1) begin
            n_err++; $display("FAIL all128_ready_T273 got=%b exp=1", feat_ready);
        end
    endtask

    task automatic test_single_ch3();
        logic [127:0] fd;
        logic [15:0]  ev;
        fd = '0;
        fd[31:24] = 8'd255;
        run_frame(fd, 1'b1);
        n_cmp++;
        if (got_to || got_n != 16) begin
            n_err++; $display("FAIL ch3_count got=%0d to=%0d exp=16", got_n, got_to);
        end
        for (int i = 0; i < 16; i++) begin
            ev = (i == 0) ? 16'h0000 : 16'h0008;
            n_cmp++;
            if (got_vec[i] !== ev) begin
                n_err++; $display("FAIL ch3_step%0d got=%h exp=%h", i, got_vec[i], ev);
            end
        end
    endtask

    task automatic test_residue();
        logic [127:0] fd;
        logic [15:0]  ev;
        bit           clr;
        fd = '0;
        fd[7:0] = 8'd64;
        // Frame 0 cleared, frame 1 carries residue, frame 2 clears with accept.
        for (int f = 0; f < 3; f++) begin
            clr = (f != 1);
            run_frame(fd, clr);
            n_cmp++;
            if (got_to || got_n != 16) begin
                n_err++; $display("FAIL res%0d_count got=%0d exp=16", f, got_n);
            end
            for (int i = 0; i < 16; i++) begin
                ev = (i % 4 == 3) ? 16'h0001 : 16'h0000;
                n_cmp++;
                if (got_vec[i] !== ev) begin
                    n_err++; $display("FAIL res%0d_step%0d got=%h exp=%h", f, i, got_vec[i], ev);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] fd1, fd2;
        logic [15:0]  vec [32];
        int           st  [32];
        int           cnt, fd_cnt, fd1_t, fd2_t, n;
        bit           busy_ready;
        fd1 = '0; fd1[7:0]  = 8'd128;
        fd2 = '0; fd2[15:8] = 8'd128;
        cnt = 0; fd_cnt = 0; fd1_t = -100; fd2_t = -100; busy_ready = 0;
        @(negedge clk);
        feat_data  = fd1;
        feat_valid = 1'b1;
        clear_acc  = 1'b1;
        @(negedge clk);
        clear_acc  = 1'b0;
        feat_data  = fd2;
        n = 1;
        while (fd_cnt < 2 && n < 700) begin
            if (n == 100 && feat_ready !== 1'b0) busy_ready = 1;
            if (spike_valid) begin
                if (cnt < 32) begin
                    vec[cnt] = spikes_out;
                    st[cnt]  = n;
                end
                cnt++;
            end
            if (frame_done) begin
                if (fd_cnt == 0) fd1_t = n;
                else fd2_t = n;
                fd_cnt++;
            end
            if (n == fd1_t + 1) begin
                n_cmp++;
                if (feat_ready !== 1'b1) begin
                    n_err++; $display("FAIL b2b_ready_after_done got=%b exp=1", feat_ready);
                end
            end
            if (n == fd1_t + 2) feat_valid = 1'b0;
            @(negedge clk);
            n++;
        end
        feat_valid = 1'b0;
        n_cmp++;
        if (busy_ready) begin
            n_err++; $display("FAIL b2b_ready_busy got=1 exp=0");
        end
        n_cmp++;
        if (cnt != 32 || fd1_t != 272 || fd2_t != fd1_t + 273) begin
            n_err++; $display("FAIL b2b_totals got cnt=%0d fd1=%0d fd2=%0d exp 32 272 545",
                              cnt, fd1_t, fd2_t);
        end
        if (cnt >= 18) begin
            n_cmp++;
            if (st[16] != fd1_t + 18) begin
                n_err++; $display("FAIL b2b_second_first_t got=%0d exp=%0d", st[16], fd1_t + 18);
            end
            n_cmp++;
            if (vec[15] !== 16'h0001 || vec[16] !== 16'h0000 || vec[17] !== 16'h0002) begin
                n_err++; $display("FAIL b2b_vectors got=%h %h %h exp=0001 0000 0002",
                                  vec[15], vec[16], vec[17]);
            end
        end else begin
            n_cmp++; n_err++;
            $display("FAIL b2b_too_few_strobes got=%0d exp=32", cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] fd;
        logic [15:0]  ev;
        int           waitc, cnt;
        fd = '0;
        fd[7:0]   = 8'd128;
        fd[23:16] = 8'd255;
        @(negedge clk);
        feat_data  = fd;
        feat_valid = 1'b1;
        clear_acc  = 1'b1;
        @(negedge clk);
        feat_valid = 1'b0;
        clear_acc  = 1'b0;
        waitc = 0;
        while (!(step_idx == 4'd5 && !spike_valid) && waitc < 300) begin
            @(negedge clk);
            waitc++;
        end
        n_cmp++;
        if (waitc >= 300 || spikes_out !== 16'h0004) begin
            n_err++; $display("FAIL mid_before_reset got=%h wait=%0d exp=0004", spikes_out, waitc);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (feat_ready !== 1'b1 || spikes_out !== 16'h0000 || spike_valid !== 1'b0 ||
            step_idx !== 4'd0) begin
            n_err++;
            $display("FAIL mid_after_reset got rdy=%b spk=%h sv=%b step=%0d exp 1 0000 0 0",
                     feat_ready, spikes_out, spike_valid, step_idx);
        end
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (spike_valid) cnt++;
        end
        n_cmp++;
        if (cnt != 0) begin
            n_err++; $display("FAIL mid_no_strobe got=%0d exp=0", cnt);
        end
        fd = '0;
        fd[7:0] = 8'd128;
        run_frame(fd, 1'b0);
        n_cmp++;
        if (got_to || got_n != 16) begin
            n_err++; $display("FAIL mid_count got=%0d exp=16", got_n);
        end
        for (int i = 0; i < 16; i++) begin
            ev = (i % 2 == 1) ? 16'h0001 : 16'h0000;
            n_cmp++;
            if (got_vec[i] !== ev) begin
                n_err++; $display("FAIL mid_step%0d got=%h exp=%h", i, got_vec[i], ev);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        feat_data  = '0;
        feat_valid = 1'b0;
        clear_acc  = 1'b0;
        test_reset();
        test_all128();
        test_single_ch3();
        test_residue();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/snn_spike_encoder16.md
Name: snn_spike_encoder16

Overview:
Feeds the SNN core. Converts one 16-channel frame of audio feature magnitudes (filterbank energies) into a train of 16-bit spike vectors on the core's input_spikes/spike_valid interface. Uses per-channel integrate-and-fire (sigma-delta) rate coding: spike rate per time step = feature/THRESH. Accumulators are scanned serially, one channel per cycle, so the block needs a single adder/comparator.

Parameters:
NUM_CH, 16, channel count and spike vector width; fixed at 16 to match the core input.
FEAT_W, 8, feature magnitude width, unsigned.
ACC_W, 10, accumulator width; must hold THRESH-1 + 2^FEAT_W-1.
THRESH, 256, firing threshold; must be >= 2^FEAT_W, so there is at most one spike per channel per step.
STEPS, 16, time steps emitted per accepted feature frame (>= 2).
LEAK_SHIFT, 4, leak divisor exponent; used only with SPIKE_ENC_LEAK_EN.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
feat_data  in  NUM_CH*FEAT_W  feature frame; channel c is at bits [c*FEAT_W +: FEAT_W].
feat_valid  in  1  feature frame valid.
feat_ready  out  1  encoder can accept a frame.
clear_acc  in  1  zero all accumulators; honoured in IDLE only.
spikes_out  out  NUM_CH  spike vector; connects to the core's input_spikes.
spike_valid  out  1  one-cycle strobe per time step; connects to the core's spike_valid.
step_idx  out  4  index of the step currently being emitted.
frame_done  out  1  pulses together with the last spike_valid of a frame.

Behaviour:
- Reset (synchronous, active-high), all values take effect the next cycle:
  - state=IDLE, all accumulators 0, feature register 0, spikes_out 0.
  - spike_valid 0, frame_done 0, step_idx 0, ch_idx 0.
  - feat_ready is a decode of state==IDLE, so it is 1 once reset is released.
- FSM states: IDLE, SCAN, EMIT.
- IDLE:
  - feat_ready=1.
  - clear_acc=1 zeroes all accumulators.
  - feat_valid&feat_ready: latch feat_data, step_idx=0, ch_idx=0, go to SCAN.
  - clear_acc and feat_valid in the same cycle: clear and accept both happen; step 0 starts from zero.
- SCAN, one channel per cycle, ch_idx 0..NUM_CH-1:
  - sum = acc[ch] + feat[ch], computed at ACC_W bits.
  - sum >= THRESH: acc[ch] = sum - THRESH, spike_bit[ch]=1.
  - Otherwise: acc[ch] = sum, spike_bit[ch]=0.
  - After ch_idx=NUM_CH-1, go to EMIT.
- EMIT (1 cycle):
  - spikes_out = assembled vector; spike_valid=1.
  - If step_idx==STEPS-1: frame_done=1, go to IDLE.
  - Otherwise: step_idx++, ch_idx=0, go to SCAN.
- spikes_out holds its last value between strobes.
- spike_valid and frame_done are high for exactly one cycle.
- feat_ready=0 in SCAN and EMIT. feat_valid held there is not consumed and stays pending until IDLE.
- clear_acc outside IDLE is ignored.
- Latency: frame accepted in cycle T.
  - First spike_valid in cycle T+NUM_CH+1 (T+17).
  - Subsequent strobes every NUM_CH+1 cycles.
  - Last strobe in cycle T+STEPS*(NUM_CH+1) (T+272).
  - feat_ready=1 from cycle T+273.
- Accumulator residues carry across frames unless clear_acc is applied. This is intended for continuous speech.
- Feature 0 never spikes. A feature of 2^FEAT_W-1 spikes on 15 of 16 steps from a cleared accumulator.
- No overflow is possible under the parameter constraints. Violating the constraints is a configuration error; the block does not detect it.
- Reset mid-operation (any state) aborts the frame: no further strobes, accumulators cleared, IDLE next cycle.

Optional Feature:
Macro SPIKE_ENC_LEAK_EN.
- Defined: in SCAN, leak is applied before the add: acc[ch] = acc[ch] - (acc[ch] >> LEAK_SHIFT), then feat[ch] is added and the threshold compared as above.
  - The leak is applied once per channel per step.
  - Weak features decay instead of eventually firing.
- Undefined: pure integrate-and-fire with no leak logic; behaviour is exactly as in the base description.

Test Plan:
1. Reset held 3 cycles, then released -> spikes_out=0, spike_valid=0, frame_done=0, feat_ready=1; no strobe for 20 idle cycles.
2. All channels 128, accumulators cleared -> 16 strobes spaced 17 cycles apart, first at T+17. Vectors alternate 0x0000, 0xFFFF starting with 0x0000. frame_done coincides with the 16th strobe (0xFFFF). feat_ready=1 at T+273.
3. Channel 3=255, others 0, cleared -> bit 3 clear at step 0 and set at steps 1..15 (15 spikes); all other bits 0 on every strobe.
4. Channel 0=64, two consecutive frames, no clear -> bit 0 set at steps 3,7,11,15 in both frames. Repeat with clear_acc asserted with the second feat_valid -> same pattern.
5. feat_valid held high during SCAN/EMIT with a second frame -> that frame is not accepted until feat_ready=1. It is accepted in the cycle after frame_done, and exactly 32 strobes occur in total.
6. Reset pulsed for 1 cycle during step 5 SCAN -> no further spike_valid, feat_ready=1 and spikes_out=0 next cycle. A new frame with channel 0=128 then first spikes at step 1, confirming the accumulators were cleared.
